// File: rtl/lcd_pkg.sv
// Shared definitions for the debug LCD front-panel blocks: FSM encoding,
// 50 MHz default bus timing and the fixed write-direction level.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_EN_HI = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } lcd_state_e;

   localparam int SETUP_CYC_DEF = 4;
   localparam int EN_CYC_DEF    = 16;
   localparam int HOLD_CYC_DEF  = 4;
   localparam int CNT_W_DEF     = 8;

   localparam logic LCD_RW_WRITE = 1'b0;

endpackage

// File: rtl/lcd_rise_detect.sv
// Registered rising-edge detector; the request output is high for the cycle
// in which i_in is high and was low on the previous clock.
module lcd_rise_detect (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic i_in,
   output logic o_rise
);

   logic r_in_d;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) r_in_d <= 1'b0;
      else         r_in_d <= i_in;
   end

   // Delayed copy resets low, so a level already high out of reset is a request.
   assign o_rise = i_in & ~r_in_d;

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780-style single-byte write engine: latches a byte and RS on a start
// edge, then runs setup / enable-pulse / hold timing and pulses oDone.
module lcd_write_engine
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int EN_CYC    = EN_CYC_DEF,
   parameter int HOLD_CYC  = HOLD_CYC_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic [7:0]       iDATA,
   input  logic             iRS,
   input  logic             iStart,
   output logic             oDone,
   output logic             oBusy,
   output logic [7:0]       LCD_DATA,
   output logic             LCD_RW,
   output logic             LCD_EN,
   output logic             LCD_RS,
   output lcd_state_e       oState
);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   lcd_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_data;
   logic             r_rs;
   logic             r_en;
   logic             r_busy;
   logic             r_done;
   logic             w_req;

   lcd_rise_detect u_start_edge (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .i_in   (iStart),
      .o_rise (w_req)
   );

   // Each timed state leaves at its terminal count, so the counter never wraps.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_data  <= 8'h00;
         r_rs    <= 1'b0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_data  <= iDATA;
                  r_rs    <= iRS;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_en    <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_EN_HI;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_EN_HI: begin
               if (r_cnt == EN_LAST) begin
                  r_en    <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_en    <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign LCD_DATA = r_data;
   assign LCD_RS   = r_rs;
   assign LCD_EN   = r_en;
   assign LCD_RW   = LCD_RW_WRITE;
   assign oBusy    = r_busy;
   assign oDone    = r_done;
   assign oState   = r_state;

endmodule
